sys_ctrl: RTL and testbench
===========================

SYS_CTRL -- requirements
Module: sys_ctrl

Interface
REQ-001 Parameters SHALL be as follows:
- CMD_BITS, default 8: command code width.
- CMD_GET_VERSION / CMD_SYNC_TIME / CMD_GET_TIME / CMD_SHUTDOWN / CMD_CLEAR / CMD_SET_MASK / CMD_WATCHDOG, defaults 0..6: command codes.
- RSP_GET_VERSION / RSP_GET_TIME / RSP_SHUTDOWN, defaults 0..2: response codes.
- VERSION, default 0: version word.
- NFAULT, default 8: fault source count, 1..24.
- LATCH_EDGE, default 0: 0 = falling, 1 = rising timesync edge.
- SYNC_OFFSET, default 4: sync compensation in cycles.
REQ-002 Ports SHALL be as follows:
- clk, in, 1: clock.
- rst_n, in, 1: reset; asynchronous, active-low.
- systime, in, 32: current system time low word.
- arg_data, in, 32: current argument word.
- arg_advance, out, 1: consume argument; tied to 1.
- cmd, in, CMD_BITS: command code.
- cmd_ready, in, 1: command valid, one cycle.
- cmd_done, out, 1: command complete pulse.
- param_data, out, 32: response word.
- param_write, out, 1: param_data valid.
- invol_req, out, 1: request an involuntary response slot.
- invol_grant, in, 1: slot granted.
- time_in, in, 64: current 64-bit time.
- time_out, out, 64: new time value.
- time_out_en, out, 1: load time_out, one-cycle pulse.
- timesync_latch_in, in, 1: asynchronous sync pulse.
- fault, in, NFAULT: fault sources, level-sensitive.
- shutdown, out, 1: system shut down, sticky.

Function
REQ-003 timesync_latch_in SHALL pass through a 2-flop synchroniser; on the selected edge of the synchronised signal, latched_time SHALL capture time_in.
REQ-004 The FSM SHALL have the states IDLE, VER1, VER2, VER3, SYNC1, TIME1, TIME2, WAITG, SD1, SD2; cmd_ready SHALL only be accepted in IDLE.
REQ-005 GET_VERSION SHALL emit, with param_write=1:
- VERSION;
- {8'd0, NFAULT[7:0], 16'd0};
- {8'd0, fault_mask[23:0]}.
The next cycle SHALL drive cmd_done=1, param_write=0, param_data=RSP_GET_VERSION, returning to IDLE.
REQ-006 SYNC_TIME SHALL take arg lo in the accept cycle and arg hi in the next cycle (SYNC1).
- In SYNC1: time_out = time_in - latched_time + {hi, lo} + SYNC_OFFSET, modulo 2^64.
- In SYNC1: time_out_en=1 and cmd_done=1 for one cycle; no param words.
REQ-007 GET_TIME SHALL emit time_in[31:0] (captured at accept), then the captured time_in[63:32], then the RSP_GET_TIME done cycle as in REQ-005.
REQ-008 SHUTDOWN SHALL set shutdown=1 and pulse cmd_done in the accept cycle; no param words.
REQ-009 CLEAR SHALL clear shutdown, fault_latch and the watchdog-expired flag, and pulse cmd_done; fault inputs still asserted SHALL re-latch on the next cycle.
REQ-010 SET_MASK SHALL load fault_mask <= arg_data[NFAULT-1:0] and pulse cmd_done.
REQ-011 WATCHDOG SHALL load wdt_reload <= arg_data and pulse cmd_done.
- wdt_reload=0 disables the watchdog.
- Otherwise the counter reloads on every accepted cmd_ready and decrements each cycle.
- Reaching 0 sets wdt_expired.
REQ-012 fault_latch SHALL OR in (fault & fault_mask) every cycle while shutdown=0; bits SHALL be sticky until CLEAR.
REQ-013 In IDLE with cmd_ready=0, shutdown=0 and (|fault_latch or wdt_expired), the block SHALL set invol_req=1 and go to WAITG.
REQ-014 In WAITG, on invol_grant:
- invol_req=0;
- emit {wdt_expired, 7'd0, fault_latch zero-extended to 24};
- then systime;
- then the done cycle with param_data=RSP_SHUTDOWN and shutdown=1.
REQ-015 cmd_ready arriving in the same cycle as an invol_req condition SHALL win; the fault SHALL be serviced after that command completes.
REQ-016 cmd_ready received outside IDLE SHALL be ignored; the upstream guarantees it does not occur.
REQ-017 cmd_done and time_out_en SHALL be single-cycle pulses; param_write SHALL stay high across all data words of one response.
REQ-018 Unknown command codes SHALL pulse cmd_done with no param words.

Reset
REQ-019 On rst_n=0, asynchronously:
- state=IDLE;
- all outputs 0, with arg_advance=1;
- fault_mask all ones;
- wdt_reload=0;
- latched_time=0 and all latches cleared.
REQ-020 A reset mid-response SHALL abort the response; there SHALL be no partial cmd_done after release.

Verification
REQ-021 GET_VERSION with VERSION=0x12345678, NFAULT=8 -> words 0x12345678, 0x00080000, 0x000000FF, then cmd_done with param_data=RSP_GET_VERSION.
REQ-022 Falling sync edge while time_in=1000; SYNC_TIME lo=5000, hi=0 issued while time_in=1100 -> time_out=5104 and time_out_en pulse in SYNC1.
REQ-023 fault[2]=1 with mask 0xFB -> no invol_req; set mask to 0xFF -> invol_req; after grant, words 0x00000004 and systime, then RSP_SHUTDOWN with shutdown=1.
REQ-024 WATCHDOG arg=10, no further commands -> invol_req 11 cycles after done; reason word 0x80000000.
REQ-025 cmd_ready coinciding with a new fault -> command completes first, then invol_req.
REQ-026 rst_n low during VER2 -> all outputs 0 immediately; a GET_VERSION after release completes normally.

Source files
------------

// File: rtl/sys_ctrl_if.sv
// Signal bundle between sys_ctrl and its host: command/response, time, sync and fault lines.
interface sys_ctrl_if #(
   parameter int CMD_BITS = 8,
   parameter int NFAULT   = 8
);
   logic [31:0]         systime;
   logic [31:0]         arg_data;
   logic                arg_advance;
   logic [CMD_BITS-1:0] cmd;
   logic                cmd_ready;
   logic                cmd_done;
   logic [31:0]         param_data;
   logic                param_write;
   logic                invol_req;
   logic                invol_grant;
   logic [63:0]         time_in;
   logic [63:0]         time_out;
   logic                time_out_en;
   logic                timesync_latch_in;
   logic [NFAULT-1:0]   fault;
   logic                shutdown;

   modport slave (
      input  systime, arg_data, cmd, cmd_ready, invol_grant, time_in,
             timesync_latch_in, fault,
      output arg_advance, cmd_done, param_data, param_write, invol_req,
             time_out, time_out_en, shutdown
   );

   modport master (
      output systime, arg_data, cmd, cmd_ready, invol_grant, time_in,
             timesync_latch_in, fault,
      input  arg_advance, cmd_done, param_data, param_write, invol_req,
             time_out, time_out_en, shutdown
   );
endinterface

// File: rtl/sys_ctrl.sv
// System controller: command decoder, time sync, fault/watchdog supervision with involuntary
// shutdown reports. All outputs are registered; each FSM state emits the next response word.
module sys_ctrl #(
   parameter int                  CMD_BITS        = 8,
   parameter logic [CMD_BITS-1:0] CMD_GET_VERSION = CMD_BITS'(0),
   parameter logic [CMD_BITS-1:0] CMD_SYNC_TIME   = CMD_BITS'(1),
   parameter logic [CMD_BITS-1:0] CMD_GET_TIME    = CMD_BITS'(2),
   parameter logic [CMD_BITS-1:0] CMD_SHUTDOWN    = CMD_BITS'(3),
   parameter logic [CMD_BITS-1:0] CMD_CLEAR       = CMD_BITS'(4),
   parameter logic [CMD_BITS-1:0] CMD_SET_MASK    = CMD_BITS'(5),
   parameter logic [CMD_BITS-1:0] CMD_WATCHDOG    = CMD_BITS'(6),
   parameter logic [31:0]         RSP_GET_VERSION = 32'd0,
   parameter logic [31:0]         RSP_GET_TIME    = 32'd1,
   parameter logic [31:0]         RSP_SHUTDOWN    = 32'd2,
   parameter logic [31:0]         VERSION         = 32'd0,
   parameter int                  NFAULT          = 8,
   parameter bit                  LATCH_EDGE      = 1'b0,
   parameter int unsigned         SYNC_OFFSET     = 4
) (
   input logic       clk,
   input logic       rst_n,
   sys_ctrl_if.slave bus
);
   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_VER1  = 4'd1;
   localparam logic [3:0] S_VER2  = 4'd2;
   localparam logic [3:0] S_VER3  = 4'd3;
   localparam logic [3:0] S_SYNC1 = 4'd4;
   localparam logic [3:0] S_TIME1 = 4'd5;
   localparam logic [3:0] S_TIME2 = 4'd6;
   localparam logic [3:0] S_WAITG = 4'd7;
   localparam logic [3:0] S_SD1   = 4'd8;
   localparam logic [3:0] S_SD2   = 4'd9;

   localparam logic [7:0] NFAULT_B = 8'(NFAULT);

   logic [3:0]        r_state;
   logic [2:0]        r_sync;
   logic [63:0]       r_latched_time;
   logic [31:0]       r_arg_lo;
   logic [31:0]       r_time_hi;
   logic [NFAULT-1:0] r_fault_mask;
   logic [NFAULT-1:0] r_fault_latch;
   logic [31:0]       r_wdt_reload;
   logic [31:0]       r_wdt_cnt;
   logic              r_wdt_expired;
   logic              r_cmd_done;
   logic [31:0]       r_param_data;
   logic              r_param_write;
   logic              r_invol_req;
   logic [63:0]       r_time_out;
   logic              r_time_out_en;
   logic              r_shutdown;

   logic              w_accept;
   logic              w_clear;
   logic              w_set_mask;
   logic              w_wdt_cmd;
   logic              w_wdt_hit;
   logic              w_sync_edge;
   logic [23:0]       w_mask24;
   logic [23:0]       w_latch24;

   assign w_accept    = (r_state == S_IDLE) && bus.cmd_ready;
   assign w_clear     = w_accept && (bus.cmd == CMD_CLEAR);
   assign w_set_mask  = w_accept && (bus.cmd == CMD_SET_MASK);
   assign w_wdt_cmd   = w_accept && (bus.cmd == CMD_WATCHDOG);
   assign w_wdt_hit   = !w_accept && (r_wdt_reload != '0) && (r_wdt_cnt == 32'd1);
   assign w_sync_edge = LATCH_EDGE ? (r_sync[1] && !r_sync[2]) : (!r_sync[1] && r_sync[2]);
   assign w_mask24    = 24'(r_fault_mask);
   assign w_latch24   = 24'(r_fault_latch);

   // r_sync[1:0] is the synchroniser, r_sync[2] the previous synchronised value for edge detect.
   // NOTE: every clocked block uses <= so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync         <= '0;
         r_latched_time <= '0;
      end else begin
         r_sync <= {r_sync[1:0], bus.timesync_latch_in};
         if (w_sync_edge) r_latched_time <= bus.time_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fault_mask  <= '1;
         r_fault_latch <= '0;
      end else begin
         if (w_set_mask) r_fault_mask <= bus.arg_data[NFAULT-1:0];
         if (w_clear)          r_fault_latch <= '0;
         else if (!r_shutdown) r_fault_latch <= r_fault_latch | (bus.fault & r_fault_mask);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wdt_reload  <= '0;
         r_wdt_cnt     <= '0;
         r_wdt_expired <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wdt_cnt <= w_wdt_cmd ? bus.arg_data : r_wdt_reload;
            if (w_wdt_cmd) r_wdt_reload <= bus.arg_data;
         end else if ((r_wdt_reload != '0) && (r_wdt_cnt != '0)) begin
            r_wdt_cnt <= r_wdt_cnt - 32'd1;
         end
         if (w_clear)        r_wdt_expired <= 1'b0;
         else if (w_wdt_hit) r_wdt_expired <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_arg_lo      <= '0;
         r_time_hi     <= '0;
         r_cmd_done    <= 1'b0;
         r_param_data  <= '0;
         r_param_write <= 1'b0;
         r_invol_req   <= 1'b0;
         r_time_out    <= '0;
         r_time_out_en <= 1'b0;
         r_shutdown    <= 1'b0;
      end else begin
         r_cmd_done    <= 1'b0;
         r_time_out_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_param_write <= 1'b0;
               r_param_data  <= '0;
               if (bus.cmd_ready) begin
                  case (bus.cmd)
                     CMD_GET_VERSION: begin
                        r_param_data  <= VERSION;
                        r_param_write <= 1'b1;
                        r_state       <= S_VER1;
                     end
                     CMD_SYNC_TIME: begin
                        r_arg_lo <= bus.arg_data;
                        r_state  <= S_SYNC1;
                     end
                     CMD_GET_TIME: begin
                        r_param_data  <= bus.time_in[31:0];
                        r_time_hi     <= bus.time_in[63:32];
                        r_param_write <= 1'b1;
                        r_state       <= S_TIME1;
                     end
                     CMD_SHUTDOWN: begin
                        r_shutdown <= 1'b1;
                        r_cmd_done <= 1'b1;
                     end
                     CMD_CLEAR: begin
                        r_shutdown <= 1'b0;
                        r_cmd_done <= 1'b1;
                     end
                     default: r_cmd_done <= 1'b1;
                  endcase
               end else if (!r_shutdown && ((|r_fault_latch) || r_wdt_expired)) begin
                  r_invol_req <= 1'b1;
                  r_state     <= S_WAITG;
               end
            end
            S_VER1: begin
               r_param_data <= {8'd0, NFAULT_B, 16'd0};
               r_state      <= S_VER2;
            end
            S_VER2: begin
               r_param_data <= {8'd0, w_mask24};
               r_state      <= S_VER3;
            end
            S_VER3: begin
               r_param_write <= 1'b0;
               r_param_data  <= RSP_GET_VERSION;
               r_cmd_done    <= 1'b1;
               r_state       <= S_IDLE;
            end
            S_SYNC1: begin
               // arg_data now carries the high argument word.
               r_time_out    <= bus.time_in - r_latched_time + {bus.arg_data, r_arg_lo}
                                + 64'(SYNC_OFFSET);
               r_time_out_en <= 1'b1;
               r_cmd_done    <= 1'b1;
               r_state       <= S_IDLE;
            end
            S_TIME1: begin
               r_param_data <= r_time_hi;
               r_state      <= S_TIME2;
            end
            S_TIME2: begin
               r_param_write <= 1'b0;
               r_param_data  <= RSP_GET_TIME;
               r_cmd_done    <= 1'b1;
               r_state       <= S_IDLE;
            end
            S_WAITG: begin
               if (bus.invol_grant) begin
                  r_invol_req   <= 1'b0;
                  r_param_data  <= {r_wdt_expired, 7'd0, w_latch24};
                  r_param_write <= 1'b1;
                  r_state       <= S_SD1;
               end
            end
            S_SD1: begin
               r_param_data <= bus.systime;
               r_state      <= S_SD2;
            end
            S_SD2: begin
               r_param_write <= 1'b0;
               r_param_data  <= RSP_SHUTDOWN;
               r_cmd_done    <= 1'b1;
               r_shutdown    <= 1'b1;
               r_state       <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.arg_advance = 1'b1;
   assign bus.cmd_done    = r_cmd_done;
   assign bus.param_data  = r_param_data;
   assign bus.param_write = r_param_write;
   assign bus.invol_req   = r_invol_req;
   assign bus.time_out    = r_time_out;
   assign bus.time_out_en = r_time_out_en;
   assign bus.shutdown    = r_shutdown;
endmodule

// File: tb/tb_sys_ctrl.sv
// Self-checking bench for sys_ctrl: vector table, directed corner sequences and a randomized
// command stream compared against a response-level model.
module tb_sys_ctrl;
   localparam logic [7:0]  C_VER  = 8'd0;
   localparam logic [7:0]  C_SYNC = 8'd1;
   localparam logic [7:0]  C_TIME = 8'd2;
   localparam logic [7:0]  C_SD   = 8'd3;
   localparam logic [7:0]  C_CLR  = 8'd4;
   localparam logic [7:0]  C_MASK = 8'd5;
   localparam logic [7:0]  C_WDT  = 8'd6;
   localparam logic [31:0] VER    = 32'h1234_5678;

   typedef struct {
      string       name;
      logic [7:0]  cmd;
      logic [31:0] arg;
      logic [63:0] tin;
      int          nwords;
      logic [31:0] w0, w1, w2;
      logic [31:0] done_data;
      logic        shut;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   sys_ctrl_if #(.CMD_BITS(8), .NFAULT(8)) bus ();

   sys_ctrl #(.VERSION(VER)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not reach its end, required completion");
      $fatal(1, "global timeout");
   end

   logic [31:0] got_words[$];
   logic [31:0] exp_w[$];
   logic        got_done, got_ten, got_pw_done, got_shut;
   logic [31:0] got_done_data;
   logic [63:0] got_time_out;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Records response words until cmd_done; caller stands at the negedge after the trigger edge.
   task automatic collect(input string name, input int budget);
      got_words.delete();
      got_done = 0; got_ten = 0; got_pw_done = 0; got_shut = 0;
      got_done_data = '0; got_time_out = '0;
      for (int n = 0; n < budget && !got_done; n++) begin
         if (n > 0) tick();
         if (bus.time_out_en) begin
            got_ten      = 1;
            got_time_out = bus.time_out;
         end
         if (bus.cmd_done) begin
            got_done      = 1;
            got_done_data = bus.param_data;
            got_pw_done   = bus.param_write;
            got_shut      = bus.shutdown;
         end else if (bus.param_write) begin
            got_words.push_back(bus.param_data);
         end
      end
      check({name, "_done_seen"}, 64'(got_done), 64'd1);
   endtask

   task automatic run_cmd(input string name, input logic [7:0] c, input logic [31:0] lo,
                          input logic [31:0] hi);
      bus.cmd       = c;
      bus.arg_data  = lo;
      bus.cmd_ready = 1'b1;
      tick();
      bus.cmd_ready = 1'b0;
      bus.arg_data  = hi;
      collect(name, 12);
      bus.arg_data  = '0;
   endtask

   task automatic check_resp(input string name, input logic [31:0] exp_done,
                             input logic exp_shut);
      check({name, "_nwords"}, 64'(got_words.size()), 64'(exp_w.size()));
      foreach (exp_w[i])
         check($sformatf("%s_word%0d", name, i),
               64'((i < got_words.size()) ? got_words[i] : 32'hDEAD_BEEF), 64'(exp_w[i]));
      if (exp_w.size() > 0) begin
         check({name, "_done_data"}, 64'(got_done_data), 64'(exp_done));
         check({name, "_pw_at_done"}, 64'(got_pw_done), 64'd0);
      end
      check({name, "_shutdown"}, 64'(got_shut), 64'(exp_shut));
   endtask

   task automatic wait_invol(input int budget, output int cycles);
      cycles = -1;
      for (int n = 1; n <= budget; n++) begin
         tick();
         if (bus.invol_req) begin
            cycles = n;
            break;
         end
      end
   endtask

   task automatic grant_and_collect(input string name);
      bus.invol_grant = 1'b1;
      tick();
      bus.invol_grant = 1'b0;
      check({name, "_req_dropped"}, 64'(bus.invol_req), 64'd0);
      collect(name, 10);
   endtask

   task automatic sync_pulse(input logic [63:0] t);
      bus.time_in           = t;
      bus.timesync_latch_in = 1'b1;
      repeat (3) tick();
      bus.timesync_latch_in = 1'b0;
      repeat (4) tick();
   endtask

   vec_t        vecs[$];
   logic [7:0]  m_mask;
   logic        m_shut;
   logic [63:0] m_latched;
   int          op, cyc, seen;
   logic [63:0] tin, exp_to;
   logic [31:0] lo, hi;
   logic [7:0]  ucmd;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n                 = 1'b0;
      bus.systime           = '0;
      bus.arg_data          = '0;
      bus.cmd               = '0;
      bus.cmd_ready         = 1'b0;
      bus.invol_grant       = 1'b0;
      bus.time_in           = '0;
      bus.timesync_latch_in = 1'b0;
      bus.fault             = '0;

      vecs.push_back('{"ver_default", C_VER, 32'd0, 64'd0, 3,
                       VER, 32'h0008_0000, 32'h0000_00FF, 32'd0, 1'b0});
      vecs.push_back('{"get_time", C_TIME, 32'd0, 64'h0123_4567_89AB_CDEF, 2,
                       32'h89AB_CDEF, 32'h0123_4567, 32'd0, 32'd1, 1'b0});
      vecs.push_back('{"mask_fb", C_MASK, 32'hFFFF_FFFB, 64'd0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0});
      vecs.push_back('{"ver_mask_fb", C_VER, 32'd0, 64'd0, 3,
                       VER, 32'h0008_0000, 32'h0000_00FB, 32'd0, 1'b0});
      vecs.push_back('{"unknown_55", 8'h55, 32'd0, 64'd0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0});
      vecs.push_back('{"shutdown", C_SD, 32'd0, 64'd0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1});
      vecs.push_back('{"ver_in_sd", C_VER, 32'd0, 64'd0, 3,
                       VER, 32'h0008_0000, 32'h0000_00FB, 32'd0, 1'b1});
      vecs.push_back('{"clear", C_CLR, 32'd0, 64'd0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0});
      vecs.push_back('{"mask_ff", C_MASK, 32'h0000_00FF, 64'd0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0});
      vecs.push_back('{"ver_mask_ff", C_VER, 32'd0, 64'd0, 3,
                       VER, 32'h0008_0000, 32'h0000_00FF, 32'd0, 1'b0});

      // Reset state
      repeat (3) tick();
      check("rst_cmd_done",    64'(bus.cmd_done),    64'd0);
      check("rst_param_write", 64'(bus.param_write), 64'd0);
      check("rst_param_data",  64'(bus.param_data),  64'd0);
      check("rst_invol_req",   64'(bus.invol_req),   64'd0);
      check("rst_time_out",    bus.time_out,         64'd0);
      check("rst_time_out_en", 64'(bus.time_out_en), 64'd0);
      check("rst_shutdown",    64'(bus.shutdown),    64'd0);
      check("rst_arg_advance", 64'(bus.arg_advance), 64'd1);
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) begin
         bus.time_in = vecs[i].tin;
         run_cmd(vecs[i].name, vecs[i].cmd, vecs[i].arg, 32'd0);
         exp_w.delete();
         if (vecs[i].nwords > 0) exp_w.push_back(vecs[i].w0);
         if (vecs[i].nwords > 1) exp_w.push_back(vecs[i].w1);
         if (vecs[i].nwords > 2) exp_w.push_back(vecs[i].w2);
         check_resp(vecs[i].name, vecs[i].done_data, vecs[i].shut);
         check({vecs[i].name, "_no_time_out_en"}, 64'(got_ten), 64'd0);
      end

      // Time sync: falling edge at 1000, command at 1100
      sync_pulse(64'd1000);
      bus.time_in = 64'd1100;
      run_cmd("sync", C_SYNC, 32'd5000, 32'd0);
      check("sync_ten", 64'(got_ten), 64'd1);
      check("sync_time_out", got_time_out, 64'd5104);
      check("sync_nwords", 64'(got_words.size()), 64'd0);
      tick();
      check("sync_ten_pulse", 64'(bus.time_out_en), 64'd0);
      check("sync_done_pulse", 64'(bus.cmd_done), 64'd0);

      // Masked fault stays silent, unmasking raises the involuntary report
      run_cmd("mask_fb2", C_MASK, 32'h0000_00FB, 32'd0);
      bus.fault = 8'h04;
      seen = 0;
      repeat (6) begin
         tick();
         if (bus.invol_req) seen++;
      end
      check("masked_no_invol", 64'(seen), 64'd0);
      run_cmd("mask_ff2", C_MASK, 32'h0000_00FF, 32'd0);
      wait_invol(8, cyc);
      check("unmasked_invol_seen", 64'(cyc > 0), 64'd1);
      bus.systime = 32'hCAFE_0123;
      grant_and_collect("fault_rpt");
      exp_w = '{32'h0000_0004, 32'hCAFE_0123};
      check_resp("fault_rpt", 32'd2, 1'b1);
      bus.fault = 8'h00;
      run_cmd("clear_f", C_CLR, 32'd0, 32'd0);
      check("clear_f_shutdown", 64'(got_shut), 64'd0);
      wait_invol(5, cyc);
      check("clear_f_no_invol", 64'(cyc), 64'hFFFF_FFFF_FFFF_FFFF);

      // Command and new fault in the same cycle: command first
      bus.fault     = 8'h01;
      bus.cmd       = C_VER;
      bus.cmd_ready = 1'b1;
      tick();
      bus.cmd_ready = 1'b0;
      collect("race_ver", 12);
      check("race_no_invol_at_done", 64'(bus.invol_req), 64'd0);
      exp_w = '{VER, 32'h0008_0000, 32'h0000_00FF};
      check_resp("race_ver", 32'd0, 1'b0);
      wait_invol(6, cyc);
      check("race_invol_after", 64'(cyc > 0), 64'd1);
      bus.systime = 32'h0000_BEEF;
      grant_and_collect("race_rpt");
      exp_w = '{32'h0000_0001, 32'h0000_BEEF};
      check_resp("race_rpt", 32'd2, 1'b1);
      bus.fault = 8'h00;
      run_cmd("clear_r", C_CLR, 32'd0, 32'd0);

      // Watchdog expiry timing
      run_cmd("wdt10", C_WDT, 32'd10, 32'd0);
      wait_invol(30, cyc);
      check("wdt_invol_delay", 64'(cyc), 64'd11);
      bus.systime = 32'h0000_0777;
      grant_and_collect("wdt_rpt");
      exp_w = '{32'h8000_0000, 32'h0000_0777};
      check_resp("wdt_rpt", 32'd2, 1'b1);
      run_cmd("wdt_off", C_WDT, 32'd0, 32'd0);
      run_cmd("clear_w", C_CLR, 32'd0, 32'd0);
      wait_invol(15, cyc);
      check("wdt_off_no_invol", 64'(cyc), 64'hFFFF_FFFF_FFFF_FFFF);

      // Randomized command stream against the response model
      m_mask = 8'hFF; m_shut = 1'b0; m_latched = 64'd1000;
      for (int it = 0; it < 60; it++) begin
         op  = int'($urandom_range(7, 0));
         tin = {$urandom, $urandom};
         lo  = $urandom;
         hi  = $urandom;
         bus.time_in = tin;
         exp_w.delete();
         if (op == 7) begin
            sync_pulse(tin);
            m_latched = tin;
         end else begin
            case (op)
               0: begin
                  run_cmd("rnd_ver", C_VER, lo, hi);
                  exp_w = '{VER, 32'h0008_0000, {24'd0, m_mask}};
                  check_resp("rnd_ver", 32'd0, m_shut);
               end
               1: begin
                  run_cmd("rnd_time", C_TIME, lo, hi);
                  exp_w = '{tin[31:0], tin[63:32]};
                  check_resp("rnd_time", 32'd1, m_shut);
               end
               2: begin
                  run_cmd("rnd_mask", C_MASK, lo, hi);
                  m_mask = lo[7:0];
                  check_resp("rnd_mask", 32'd0, m_shut);
               end
               3: begin
                  run_cmd("rnd_sync", C_SYNC, lo, hi);
                  exp_to = tin - m_latched + {hi, lo} + 64'd4;
                  check("rnd_sync_ten", 64'(got_ten), 64'd1);
                  check("rnd_sync_time_out", got_time_out, exp_to);
                  check_resp("rnd_sync", 32'd0, m_shut);
               end
               4: begin
                  run_cmd("rnd_clear", C_CLR, lo, hi);
                  m_shut = 1'b0;
                  check_resp("rnd_clear", 32'd0, m_shut);
               end
               5: begin
                  run_cmd("rnd_sd", C_SD, lo, hi);
                  m_shut = 1'b1;
                  check_resp("rnd_sd", 32'd0, m_shut);
               end
               default: begin
                  ucmd = 8'($urandom_range(255, 7));
                  run_cmd("rnd_unknown", ucmd, lo, hi);
                  check_resp("rnd_unknown", 32'd0, m_shut);
               end
            endcase
            if (op != 3) check("rnd_no_ten", 64'(got_ten), 64'd0);
            tick();
            check("rnd_done_pulse", 64'(bus.cmd_done), 64'd0);
         end
      end

      // Reset during VER2 aborts the response
      bus.cmd       = C_VER;
      bus.cmd_ready = 1'b1;
      tick();
      bus.cmd_ready = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("midrst_param_write", 64'(bus.param_write), 64'd0);
      check("midrst_param_data",  64'(bus.param_data),  64'd0);
      check("midrst_cmd_done",    64'(bus.cmd_done),    64'd0);
      check("midrst_shutdown",    64'(bus.shutdown),    64'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      seen = 0;
      repeat (5) begin
         tick();
         if (bus.cmd_done || bus.param_write) seen++;
      end
      check("midrst_no_partial", 64'(seen), 64'd0);
      run_cmd("post_rst_ver", C_VER, 32'd0, 32'd0);
      exp_w = '{VER, 32'h0008_0000, 32'h0000_00FF};
      check_resp("post_rst_ver", 32'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
